zx_ps2_keymatrix: RTL and testbench

- Converts the 11-bit PS/2 key event word from the HPS I/O block into a live 8x5 ZX Spectrum keyboard matrix.
- The TSConf core reads the matrix through the Z80 high address byte.
- Sits between hps_io (ps2_key) and tsconf's keyboard port read path.
- Also produces the F11 / Shift+F11 reset request strobes that the top level routes to the configured reset-vector logic.

---
 rtl/zx_kbd_pkg.sv | 32 +++
 rtl/zx_ps2_keymatrix_if.sv | 13 +
 rtl/zx_keymap_rom.sv | 72 +++++++
 rtl/zx_ps2_keymatrix.sv | 129 ++++++++++++
 tb/tb_zx_ps2_keymatrix.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/zx_kbd_pkg.sv
// Shared types and scancode constants for the PS/2 to ZX Spectrum keyboard matrix.
package zx_kbd_pkg;

   localparam logic [1:0] COMP_NONE = 2'd0;
   localparam logic [1:0] COMP_CS   = 2'd1;
   localparam logic [1:0] COMP_SS   = 2'd2;

   localparam logic [7:0] SC_F11    = 8'h78;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_COMMA  = 8'h41;
   localparam logic [7:0] SC_PERIOD = 8'h49;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_RIGHT  = 8'h74;

   typedef struct packed {
      logic       valid;
      logic [2:0] row;
      logic [2:0] col;
      logic [1:0] comp;
   } key_entry_t;

   function automatic key_entry_t key_at(input logic [2:0] r, input logic [2:0] c,
                                         input logic [1:0] k);
      key_at = key_entry_t'{valid: 1'b1, row: r, col: c, comp: k};
   endfunction

endpackage

// File: rtl/zx_ps2_keymatrix_if.sv
// Key-event input, Z80 row select and matrix/reset-request outputs of the keymatrix.
interface zx_ps2_keymatrix_if;
   logic [10:0] ps2_key;
   logic [7:0]  a_hi;
   logic [4:0]  kb_col;
   logic        f11_req;
   logic        shift_f11_req;

   modport master (output ps2_key, output a_hi,
                   input kb_col, input f11_req, input shift_f11_req);
   modport slave  (input ps2_key, input a_hi,
                   output kb_col, output f11_req, output shift_f11_req);
endinterface

// File: rtl/zx_keymap_rom.sv
// Combinational {ext, scancode} -> ZX matrix position lookup (standard 8x5 layout).
module zx_keymap_rom
   import zx_kbd_pkg::*;
#(
   parameter bit CURSOR_EN = 1'b1
) (
   input  logic       i_ext,
   input  logic [7:0] i_scancode,
   output key_entry_t o_entry
);

   always_comb begin
      o_entry = '0;
      if (!i_ext) begin
         case (i_scancode)
            8'h1A:     o_entry = key_at(3'd0, 3'd1, COMP_NONE); // Z
            8'h22:     o_entry = key_at(3'd0, 3'd2, COMP_NONE); // X
            8'h21:     o_entry = key_at(3'd0, 3'd3, COMP_NONE); // C
            8'h2A:     o_entry = key_at(3'd0, 3'd4, COMP_NONE); // V
            8'h1C:     o_entry = key_at(3'd1, 3'd0, COMP_NONE); // A
            8'h1B:     o_entry = key_at(3'd1, 3'd1, COMP_NONE); // S
            8'h23:     o_entry = key_at(3'd1, 3'd2, COMP_NONE); // D
            8'h2B:     o_entry = key_at(3'd1, 3'd3, COMP_NONE); // F
            8'h34:     o_entry = key_at(3'd1, 3'd4, COMP_NONE); // G
            8'h15:     o_entry = key_at(3'd2, 3'd0, COMP_NONE); // Q
            8'h1D:     o_entry = key_at(3'd2, 3'd1, COMP_NONE); // W
            8'h24:     o_entry = key_at(3'd2, 3'd2, COMP_NONE); // E
            8'h2D:     o_entry = key_at(3'd2, 3'd3, COMP_NONE); // R
            8'h2C:     o_entry = key_at(3'd2, 3'd4, COMP_NONE); // T
            8'h16:     o_entry = key_at(3'd3, 3'd0, COMP_NONE); // 1
            8'h1E:     o_entry = key_at(3'd3, 3'd1, COMP_NONE); // 2
            8'h26:     o_entry = key_at(3'd3, 3'd2, COMP_NONE); // 3
            8'h25:     o_entry = key_at(3'd3, 3'd3, COMP_NONE); // 4
            8'h2E:     o_entry = key_at(3'd3, 3'd4, COMP_NONE); // 5
            8'h45:     o_entry = key_at(3'd4, 3'd0, COMP_NONE); // 0
            8'h46:     o_entry = key_at(3'd4, 3'd1, COMP_NONE); // 9
            8'h3E:     o_entry = key_at(3'd4, 3'd2, COMP_NONE); // 8
            8'h3D:     o_entry = key_at(3'd4, 3'd3, COMP_NONE); // 7
            8'h36:     o_entry = key_at(3'd4, 3'd4, COMP_NONE); // 6
            8'h4D:     o_entry = key_at(3'd5, 3'd0, COMP_NONE); // P
            8'h44:     o_entry = key_at(3'd5, 3'd1, COMP_NONE); // O
            8'h43:     o_entry = key_at(3'd5, 3'd2, COMP_NONE); // I
            8'h3C:     o_entry = key_at(3'd5, 3'd3, COMP_NONE); // U
            8'h35:     o_entry = key_at(3'd5, 3'd4, COMP_NONE); // Y
            8'h5A:     o_entry = key_at(3'd6, 3'd0, COMP_NONE); // Enter
            8'h4B:     o_entry = key_at(3'd6, 3'd1, COMP_NONE); // L
            8'h42:     o_entry = key_at(3'd6, 3'd2, COMP_NONE); // K
            8'h3B:     o_entry = key_at(3'd6, 3'd3, COMP_NONE); // J
            8'h33:     o_entry = key_at(3'd6, 3'd4, COMP_NONE); // H
            8'h29:     o_entry = key_at(3'd7, 3'd0, COMP_NONE); // Space
            SC_CTRL:   o_entry = key_at(3'd7, 3'd1, COMP_NONE); // LCtrl = SS
            8'h3A:     o_entry = key_at(3'd7, 3'd2, COMP_NONE); // M
            8'h31:     o_entry = key_at(3'd7, 3'd3, COMP_NONE); // N
            8'h32:     o_entry = key_at(3'd7, 3'd4, COMP_NONE); // B
            SC_BKSP:   o_entry = key_at(3'd4, 3'd0, COMP_CS);
            SC_COMMA:  o_entry = key_at(3'd7, 3'd3, COMP_SS);
            SC_PERIOD: o_entry = key_at(3'd7, 3'd2, COMP_SS);
            default:   o_entry = '0;
         endcase
      end else begin
         case (i_scancode)
            SC_CTRL:  o_entry = key_at(3'd7, 3'd1, COMP_NONE);
            SC_LEFT:  if (CURSOR_EN) o_entry = key_at(3'd3, 3'd4, COMP_CS);
            SC_DOWN:  if (CURSOR_EN) o_entry = key_at(3'd4, 3'd4, COMP_CS);
            SC_UP:    if (CURSOR_EN) o_entry = key_at(3'd4, 3'd3, COMP_CS);
            SC_RIGHT: if (CURSOR_EN) o_entry = key_at(3'd4, 3'd2, COMP_CS);
            default:  o_entry = '0;
         endcase
      end
   end

endmodule

// File: rtl/zx_ps2_keymatrix.sv
// PS/2 key events -> live ZX Spectrum 8x5 matrix, read by Z80 high address byte,
// plus F11 / Shift+F11 reset request strobes.
module zx_ps2_keymatrix
   import zx_kbd_pkg::*;
#(
   parameter int unsigned CNT_W     = 3,
   parameter bit          CURSOR_EN = 1'b1
) (
   input  logic                 clk_sys,
   input  logic                 reset,
   zx_ps2_keymatrix_if.slave    kbd
);

   logic [10:0]      r_key_q;
   logic             r_toggle_old;
   logic             r_primed;
   logic [7:0][4:0]  r_keys;
   logic             r_lsh, r_rsh;
   logic [CNT_W-1:0] r_cs_cnt, r_ss_cnt;
   logic             r_f11_req, r_shift_f11_req;
   logic [4:0]       r_kb_col;

   logic [7:0][4:0]  w_keys_d;
   logic             w_lsh_d, w_rsh_d;
   logic [CNT_W-1:0] w_cs_cnt_d, w_ss_cnt_d;
   logic             w_f11_d, w_shift_f11_d;
   logic [7:0][4:0]  w_rows;
   logic [4:0]       w_sel;
   logic             w_event, w_press, w_ext, w_old;
   logic [7:0]       w_sc;
   key_entry_t       w_entry;

   // First post-reset sample seeds toggle_old straight from the input so no event fires.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_key_q      <= '0;
         r_toggle_old <= 1'b0;
         r_primed     <= 1'b0;
      end else begin
         r_key_q      <= kbd.ps2_key;
         r_toggle_old <= r_primed ? r_key_q[10] : kbd.ps2_key[10];
         r_primed     <= 1'b1;
      end
   end

   assign w_event = r_primed && (r_key_q[10] != r_toggle_old);
   assign w_press = r_key_q[9];
   assign w_ext   = r_key_q[8];
   assign w_sc    = r_key_q[7:0];

   zx_keymap_rom #(
      .CURSOR_EN (CURSOR_EN)
   ) u_rom (
      .i_ext      (w_ext),
      .i_scancode (w_sc),
      .o_entry    (w_entry)
   );

   always_comb begin
      w_keys_d      = r_keys;
      w_lsh_d       = r_lsh;
      w_rsh_d       = r_rsh;
      w_cs_cnt_d    = r_cs_cnt;
      w_ss_cnt_d    = r_ss_cnt;
      w_f11_d       = 1'b0;
      w_shift_f11_d = 1'b0;
      w_old         = r_keys[w_entry.row][w_entry.col];
      if (w_event) begin
         if (w_entry.valid) begin
            w_keys_d[w_entry.row][w_entry.col] = w_press;
            // Counters track base-bit transitions only, so typematic repeats are ignored.
            if (w_press && !w_old) begin
               if (w_entry.comp == COMP_CS && r_cs_cnt != '1) w_cs_cnt_d = r_cs_cnt + 1'b1;
               if (w_entry.comp == COMP_SS && r_ss_cnt != '1) w_ss_cnt_d = r_ss_cnt + 1'b1;
            end else if (!w_press && w_old) begin
               if (w_entry.comp == COMP_CS && r_cs_cnt != '0) w_cs_cnt_d = r_cs_cnt - 1'b1;
               if (w_entry.comp == COMP_SS && r_ss_cnt != '0) w_ss_cnt_d = r_ss_cnt - 1'b1;
            end
         end else if (!w_ext && w_sc == SC_LSHIFT) begin
            w_lsh_d = w_press;
         end else if (!w_ext && w_sc == SC_RSHIFT) begin
            w_rsh_d = w_press;
         end else if (!w_ext && w_sc == SC_F11 && w_press) begin
            w_shift_f11_d = r_lsh | r_rsh;
            w_f11_d       = ~(r_lsh | r_rsh);
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_keys          <= '0;
         r_lsh           <= 1'b0;
         r_rsh           <= 1'b0;
         r_cs_cnt        <= '0;
         r_ss_cnt        <= '0;
         r_f11_req       <= 1'b0;
         r_shift_f11_req <= 1'b0;
      end else begin
         r_keys          <= w_keys_d;
         r_lsh           <= w_lsh_d;
         r_rsh           <= w_rsh_d;
         r_cs_cnt        <= w_cs_cnt_d;
         r_ss_cnt        <= w_ss_cnt_d;
         r_f11_req       <= w_f11_d;
         r_shift_f11_req <= w_shift_f11_d;
      end
   end

   always_comb begin
      w_rows       = r_keys;
      w_rows[0][0] = r_keys[0][0] | r_lsh | r_rsh | (r_cs_cnt != '0);
      w_rows[7][1] = r_keys[7][1] | (r_ss_cnt != '0);
      w_sel        = '0;
      for (int r = 0; r < 8; r++) begin
         if (!kbd.a_hi[r]) w_sel = w_sel | w_rows[r];
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) r_kb_col <= 5'h1F;
      else       r_kb_col <= ~w_sel;
   end

   assign kbd.kb_col        = r_kb_col;
   assign kbd.f11_req       = r_f11_req;
   assign kbd.shift_f11_req = r_shift_f11_req;

endmodule

// File: tb/tb_zx_ps2_keymatrix.sv
// Self-checking bench: directed scenarios plus random key traffic against a layout-table model.
module tb_zx_ps2_keymatrix;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;

   zx_ps2_keymatrix_if kbd ();

   zx_ps2_keymatrix #(
      .CNT_W     (3),
      .CURSOR_EN (1'b1)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .kbd     (kbd)
   );

   always #5 clk_sys = ~clk_sys;

   int tests = 0;
   int fails = 0;

   // Model state: which matrix positions are held, shift flags, composite counts.
   bit held [8][5];
   int cs_cnt, ss_cnt;
   bit lsh, rsh;
   int f11_cnt, sf11_cnt, f11_seen, sf11_seen;
   bit tog;

   logic [7:0] lay [8][5] = '{
      '{8'h00, 8'h1A, 8'h22, 8'h21, 8'h2A},
      '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
      '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
      '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
      '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
      '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
      '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
      '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
   };
   logic [8:0] cx_key [7] = '{9'h066, 9'h16B, 9'h172, 9'h175, 9'h174, 9'h041, 9'h049};
   int         cx_row [7] = '{4, 3, 4, 4, 4, 7, 7};
   int         cx_col [7] = '{0, 4, 4, 3, 2, 3, 2};
   bit         cx_cs  [7] = '{1, 1, 1, 1, 1, 0, 0};

   logic [8:0] pool [22] = '{9'h01C, 9'h01B, 9'h015, 9'h029, 9'h014, 9'h114, 9'h066, 9'h16B,
                             9'h172, 9'h175, 9'h174, 9'h041, 9'h049, 9'h012, 9'h059, 9'h078,
                             9'h005, 9'h11F, 9'h03A, 9'h031, 9'h045, 9'h05A};

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] model_col(input logic [7:0] a);
      logic [4:0] acc = '0;
      for (int r = 0; r < 8; r++) begin
         if (!a[r]) begin
            for (int c = 0; c < 5; c++) begin
               bit b = held[r][c];
               if (r == 0 && c == 0) b = b | lsh | rsh | (cs_cnt > 0);
               if (r == 7 && c == 1) b = b | (ss_cnt > 0);
               if (b) acc[c] = 1'b1;
            end
         end
      end
      return ~acc;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) held[r][c] = 1'b0;
      cs_cnt = 0; ss_cnt = 0; lsh = 1'b0; rsh = 1'b0;
   endtask

   task automatic model_apply(input bit ext, input bit press, input logic [7:0] sc);
      int row = -1, col = -1, comp = 0;
      bit was;
      if (!ext && sc == 8'h12) lsh = press;
      else if (!ext && sc == 8'h59) rsh = press;
      else if (!ext && sc == 8'h78) begin
         if (press) begin
            if (lsh || rsh) sf11_cnt++;
            else f11_cnt++;
         end
      end else begin
         if (!ext) begin
            for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++)
               if (lay[r][c] != 8'h00 && lay[r][c] == sc) begin row = r; col = c; end
         end
         if (ext && sc == 8'h14) begin row = 7; col = 1; end
         for (int i = 0; i < 7; i++)
            if (cx_key[i] == {ext, sc}) begin
               row = cx_row[i]; col = cx_col[i]; comp = cx_cs[i] ? 1 : 2;
            end
         if (row >= 0) begin
            was = held[row][col];
            held[row][col] = press;
            if (press && !was) begin
               if (comp == 1) cs_cnt = (cs_cnt < 7) ? cs_cnt + 1 : 7;
               if (comp == 2) ss_cnt = (ss_cnt < 7) ? ss_cnt + 1 : 7;
            end else if (!press && was) begin
               if (comp == 1 && cs_cnt > 0) cs_cnt--;
               if (comp == 2 && ss_cnt > 0) ss_cnt--;
            end
         end
      end
   endtask

   // Returns #1 after the edge on which the DUT matrix takes the event.
   task automatic send(input bit ext, input bit press, input logic [7:0] sc);
      @(negedge clk_sys);
      tog = ~tog;
      kbd.ps2_key = {tog, press, ext, sc};
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      model_apply(ext, press, sc);
   endtask

   task automatic chk_col(input string name, input logic [4:0] exp);
      @(posedge clk_sys);
      #2;
      check(name, kbd.kb_col, exp);
   endtask

   task automatic rand_ahi();
      case ($urandom_range(0, 2))
         0:       kbd.a_hi = 8'($urandom);
         1:       kbd.a_hi = ~(8'h01 << $urandom_range(0, 7));
         default: kbd.a_hi = 8'hFF;
      endcase
   endtask

   initial begin
      kbd.ps2_key = '0;
      kbd.a_hi    = 8'hFF;
      tog         = 1'b0;
      f11_cnt = 0; sf11_cnt = 0; f11_seen = 0; sf11_seen = 0;
      model_reset();
      repeat (3) @(posedge clk_sys);
      #2;
      check("reset_kb_col", kbd.kb_col, 5'h1F);
      check("reset_f11", kbd.f11_req, 0);
      check("reset_sf11", kbd.shift_f11_req, 0);
      @(negedge clk_sys);
      reset = 1'b0;

      fork
         begin : cmp_loop
            logic [4:0] e;
            forever begin
               @(posedge clk_sys);
               e = model_col(kbd.a_hi);
               #2;
               check("cmp_kb_col", kbd.kb_col, e);
               check("cmp_f11", kbd.f11_req, f11_cnt != f11_seen);
               check("cmp_sf11", kbd.shift_f11_req, sf11_cnt != sf11_seen);
               f11_seen  = f11_cnt;
               sf11_seen = sf11_cnt;
            end
         end
      join_none

      // Plain key A
      kbd.a_hi = 8'hFD;
      send(1'b0, 1'b1, 8'h1C);
      chk_col("a_press", 5'h1E);
      send(1'b0, 1'b0, 8'h1C);
      chk_col("a_release", 5'h1F);
      kbd.a_hi = 8'hFE;
      chk_col("a_row0", 5'h1F);

      // Backspace = CS+0, held through a physical shift
      send(1'b0, 1'b1, 8'h66);
      kbd.a_hi = 8'hEF;
      chk_col("bksp_row4", 5'h1E);
      kbd.a_hi = 8'hFE;
      chk_col("bksp_row0", 5'h1E);
      send(1'b0, 1'b1, 8'h12);
      send(1'b0, 1'b0, 8'h66);
      chk_col("lsh_holds_cs", 5'h1E);
      send(1'b0, 1'b0, 8'h12);
      chk_col("lsh_release", 5'h1F);

      // Two cursor composites overlapping, then a spurious release
      send(1'b1, 1'b1, 8'h6B);
      send(1'b1, 1'b1, 8'h74);
      send(1'b1, 1'b0, 8'h6B);
      chk_col("cursor_cs_held", 5'h1E);
      kbd.a_hi = 8'hEF;
      chk_col("cursor_8_held", 5'h1B);
      send(1'b1, 1'b0, 8'h74);
      kbd.a_hi = 8'hFE;
      chk_col("cursor_cs_clear", 5'h1F);
      send(1'b1, 1'b0, 8'h74);
      chk_col("spurious_release", 5'h1F);

      // F11 strobes
      send(1'b0, 1'b1, 8'h78);
      check("f11_pulse", kbd.f11_req, 1);
      check("f11_no_shift", kbd.shift_f11_req, 0);
      @(posedge clk_sys);
      #2;
      check("f11_one_cycle", kbd.f11_req, 0);
      send(1'b0, 1'b0, 8'h78);
      check("f11_release_none", kbd.f11_req, 0);
      send(1'b0, 1'b1, 8'h59);
      send(1'b0, 1'b1, 8'h78);
      check("sf11_pulse", kbd.shift_f11_req, 1);
      check("sf11_no_f11", kbd.f11_req, 0);
      send(1'b0, 1'b0, 8'h78);
      check("sf11_release_none", kbd.shift_f11_req, 0);
      send(1'b0, 1'b0, 8'h59);

      // Reset while keys are held, then no event on first post-reset sample
      send(1'b0, 1'b1, 8'h15);
      send(1'b0, 1'b1, 8'h29);
      kbd.a_hi = 8'h00;
      chk_col("q_space_held", 5'h1E);
      @(negedge clk_sys);
      reset = 1'b1;
      model_reset();
      #1;
      check("reset_async", kbd.kb_col, 5'h1F);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) chk_col("post_reset_quiet", 5'h1F);

      // Typematic repeat of a composite
      kbd.a_hi = 8'hFE;
      repeat (3) send(1'b0, 1'b1, 8'h66);
      send(1'b0, 1'b0, 8'h66);
      chk_col("typematic_cs", 5'h1F);
      kbd.a_hi = 8'hEF;
      chk_col("typematic_0", 5'h1F);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         logic [8:0] k;
         k = pool[$urandom_range(0, 21)];
         rand_ahi();
         send(k[8], 1'($urandom_range(0, 1)), k[7:0]);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk_sys);
            rand_ahi();
         end
      end

      repeat (4) @(posedge clk_sys);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
